// File: rtl/k12a_stack_seq_if.sv
// Request/response and data-memory signals of the K12a stack sequencer.
// The master side is the sequencer; the slave side is the control unit and the memory.
interface k12a_stack_seq_if;
    logic       push_req;
    logic       pop_req;
    logic [7:0] push_data;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] pop_data;
    logic       sp_load;
    logic       sp_store;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        input  push_req, pop_req, push_data, mem_rdata,
        output busy, done, fault, pop_data, sp_load, sp_store,
        output mem_we, mem_re, mem_wdata
    );

    modport slave (
        output push_req, pop_req, push_data, mem_rdata,
        input  busy, done, fault, pop_data, sp_load, sp_store,
        input  mem_we, mem_re, mem_wdata
    );
endinterface

// File: rtl/k12a_stack_seq.sv
// K12a stack sequencer: push/pop through the shared SP address bus and one byte of stack memory.
// Optional stack-limit refusal is enabled with the macro K12A_STACK_LIMIT_EN.
module k12a_stack_seq #(
    parameter logic [15:0] STACK_EMPTY = 16'h0000,
    parameter logic [15:0] STACK_FULL  = 16'hFF00
) (
    input  logic                     cpu_clock,
    input  logic                     reset,
    k12a_stack_seq_if.master         sbus,
    inout  wire               [15:0] addr_bus
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        P_RD  = 4'd1,
        P_WB  = 4'd2,
        P_MEM = 4'd3,
        Q_RD  = 4'd4,
        Q_MEM = 4'd5,
        Q_WB  = 4'd6,
        DONE  = 4'd7
`ifdef K12A_STACK_LIMIT_EN
        , FAULT = 4'd8
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tmp_q, tmp_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  pop_data_q, pop_data_d;

    logic        sp_load;
    logic        sp_store;
    logic        mem_we;
    logic        mem_re;
    logic        done;
    logic        fault;
    logic        bus_drive;
    logic [15:0] bus_val;

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tmp_q      <= 16'h0000;
            data_q     <= 8'h00;
            pop_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            tmp_q      <= tmp_d;
            data_q     <= data_d;
            pop_data_q <= pop_data_d;
        end
    end

    // Next state; push has priority when both requests arrive together.
    always_comb begin
        state_d    = state_q;
        tmp_d      = tmp_q;
        data_d     = data_q;
        pop_data_d = pop_data_q;
        case (state_q)
            IDLE: begin
                if (sbus.push_req) begin
                    data_d  = sbus.push_data;
                    state_d = P_RD;
                end else if (sbus.pop_req) begin
                    state_d = Q_RD;
                end
            end
            P_RD: begin
`ifdef K12A_STACK_LIMIT_EN
                if (addr_bus == STACK_FULL) begin
                    state_d = FAULT;
                end else begin
                    tmp_d   = addr_bus - 16'd1;
                    state_d = P_WB;
                end
`else
                tmp_d   = addr_bus - 16'd1;
                state_d = P_WB;
`endif
            end
            P_WB:  state_d = P_MEM;
            P_MEM: state_d = DONE;
            Q_RD: begin
`ifdef K12A_STACK_LIMIT_EN
                if (addr_bus == STACK_EMPTY) begin
                    state_d = FAULT;
                end else begin
                    tmp_d   = addr_bus;
                    state_d = Q_MEM;
                end
`else
                tmp_d   = addr_bus;
                state_d = Q_MEM;
`endif
            end
            Q_MEM: begin
                pop_data_d = sbus.mem_rdata;
                state_d    = Q_WB;
            end
            Q_WB:  state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes depend on state alone; sp_load and our own bus drive never share a state.
    always_comb begin
        sp_load   = 1'b0;
        sp_store  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        bus_drive = 1'b0;
        bus_val   = tmp_q;
        case (state_q)
            P_RD:  sp_load = 1'b1;
            P_WB: begin
                bus_drive = 1'b1;
                sp_store  = 1'b1;
            end
            P_MEM: begin
                bus_drive = 1'b1;
                mem_we    = 1'b1;
            end
            Q_RD:  sp_load = 1'b1;
            Q_MEM: begin
                bus_drive = 1'b1;
                mem_re    = 1'b1;
            end
            Q_WB: begin
                bus_drive = 1'b1;
                bus_val   = tmp_q + 16'd1;
                sp_store  = 1'b1;
            end
            DONE:  done = 1'b1;
`ifdef K12A_STACK_LIMIT_EN
            FAULT: fault = 1'b1;
`endif
            default: ;
        endcase
    end

`ifndef K12A_STACK_LIMIT_EN
    logic unused_limits;
    assign unused_limits = ^{STACK_EMPTY, STACK_FULL};
`endif

    assign addr_bus       = bus_drive ? bus_val : 16'hzzzz;

    assign sbus.busy      = (state_q != IDLE);
    assign sbus.done      = done;
    assign sbus.fault     = fault;
    assign sbus.pop_data  = pop_data_q;
    assign sbus.sp_load   = sp_load;
    assign sbus.sp_store  = sp_store;
    assign sbus.mem_we    = mem_we;
    assign sbus.mem_re    = mem_re;
    assign sbus.mem_wdata = data_q;

endmodule

// File: tb/tb_k12a_stack_seq.sv
// Directed bench for k12a_stack_seq with an SP register model and a 64 KiB byte memory model.
module tb_k12a_stack_seq;

    logic        cpu_clock;
    logic        reset;
    wire  [15:0] addr_bus;

    k12a_stack_seq_if bus ();

    k12a_stack_seq dut (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .sbus      (bus.master),
        .addr_bus  (addr_bus)
    );

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    // SP register model: drives the bus on sp_load, captures it on sp_store.
    logic [15:0] sp;
    logic        sp_wr_en;
    logic [15:0] sp_wr_val;
    assign addr_bus = bus.sp_load ? sp : 16'hzzzz;

    always @(posedge cpu_clock) begin
        if (sp_wr_en)          sp <= sp_wr_val;
        else if (bus.sp_store) sp <= addr_bus;
    end

    logic [7:0] mem [0:65535];
    assign bus.mem_rdata = bus.mem_re ? mem[addr_bus] : 8'h00;
    always @(posedge cpu_clock) begin
        if (bus.mem_we) mem[addr_bus] <= bus.mem_wdata;
    end

    // Event counters sampled mid-cycle.
    int n_we, n_re, n_done, n_fault, n_clash;
    initial begin
        n_we = 0; n_re = 0; n_done = 0; n_fault = 0; n_clash = 0;
    end
    always @(negedge cpu_clock) begin
        if (bus.mem_we)                    n_we++;
        if (bus.mem_re)                    n_re++;
        if (bus.done)                      n_done++;
        if (bus.fault)                     n_fault++;
        if (bus.sp_load && dut.bus_drive)  n_clash++;
    end

    int errors;
    int checks;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic set_sp(input logic [15:0] v);
        sp_wr_en  = 1'b1;
        sp_wr_val = v;
        tick();
        sp_wr_en  = 1'b0;
    endtask

    // Issue a request and wait (bounded) for busy to drop; returns busy cycle count.
    task automatic run_op(input logic push, input logic pop, input logic [7:0] d, output int cyc);
        bus.push_req  = push;
        bus.pop_req   = pop;
        bus.push_data = d;
        tick();
        bus.push_req  = 1'b0;
        bus.pop_req   = 1'b0;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.busy) break;
            cyc++;
            tick();
        end
        if (bus.busy) chk("op_timeout", 32'd1, 32'd0);
    endtask

    int cyc, we0, re0, done0, fault0;

    initial begin
        errors = 0;
        checks = 0;
        sp_wr_en = 1'b0; sp_wr_val = 16'h0000;
        bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.push_data = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        set_sp(16'h0000);

        chk("rst_busy",     {31'd0, bus.busy},       32'd0);
        chk("rst_done",     {31'd0, bus.done},       32'd0);
        chk("rst_fault",    {31'd0, bus.fault},      32'd0);
        chk("rst_pop_data", {24'd0, bus.pop_data},   32'h00);
        chk("rst_strobes",  {28'd0, bus.sp_load, bus.sp_store, bus.mem_we, bus.mem_re}, 32'd0);
        chk("rst_release",  {31'd0, dut.bus_drive},  32'd0);

        // Push 0xA5 with SP=0x0000, checked cycle by cycle.
        bus.push_req = 1'b1; bus.push_data = 8'hA5;
        tick();
        bus.push_req = 1'b0; bus.push_data = 8'h00;
        chk("push_c1_busy",  {31'd0, bus.busy},    32'd1);
        chk("push_c1_load",  {28'd0, bus.sp_load, bus.sp_store, bus.mem_we, bus.done}, 32'b1000);
        tick();
        chk("push_c2_store", {28'd0, bus.sp_load, bus.sp_store, bus.mem_we, bus.done}, 32'b0100);
        chk("push_c2_addr",  {16'd0, addr_bus},    32'hFFFF);
        tick();
        chk("push_c3_we",    {28'd0, bus.sp_load, bus.sp_store, bus.mem_we, bus.done}, 32'b0010);
        chk("push_c3_addr",  {16'd0, addr_bus},    32'hFFFF);
        chk("push_c3_wdata", {24'd0, bus.mem_wdata}, 32'hA5);
        chk("push_c3_sp",    {16'd0, sp},          32'hFFFF);
        tick();
        chk("push_c4_done",  {30'd0, bus.busy, bus.done}, 32'b11);
        chk("push_mem",      {24'd0, mem[16'hFFFF]}, 32'hA5);
        tick();
        chk("push_c5_idle",  {30'd0, bus.busy, bus.done}, 32'b00);

        // Pop back the byte.
        done0 = n_done;
        bus.pop_req = 1'b1;
        tick();
        bus.pop_req = 1'b0;
        chk("pop_c1_load",   {29'd0, bus.sp_load, bus.sp_store, bus.mem_re}, 32'b100);
        tick();
        chk("pop_c2_re",     {29'd0, bus.sp_load, bus.sp_store, bus.mem_re}, 32'b001);
        chk("pop_c2_addr",   {16'd0, addr_bus},    32'hFFFF);
        chk("pop_c2_old",    {24'd0, bus.pop_data}, 32'h00);
        tick();
        chk("pop_c3_store",  {29'd0, bus.sp_load, bus.sp_store, bus.mem_re}, 32'b010);
        chk("pop_c3_data",   {24'd0, bus.pop_data}, 32'hA5);
        chk("pop_c3_addr",   {16'd0, addr_bus},    32'h0000);
        tick();
        chk("pop_c4_done",   {31'd0, bus.done},    32'd1);
        chk("pop_sp",        {16'd0, sp},          32'h0000);
        tick();
        chk("pop_done_once", n_done - done0,       32'd1);
        chk("pop_c5_idle",   {31'd0, bus.busy},    32'd0);

        // Simultaneous requests: push wins.
        set_sp(16'h1000);
        re0 = n_re; done0 = n_done;
        run_op(1'b1, 1'b1, 8'h3C, cyc);
        chk("both_cycles",   cyc,                  32'd4);
        chk("both_sp",       {16'd0, sp},          32'h0FFF);
        chk("both_mem",      {24'd0, mem[16'h0FFF]}, 32'h3C);
        chk("both_no_re",    n_re - re0,           32'd0);
        chk("both_done",     n_done - done0,       32'd1);

        // Reset during P_WB.
        set_sp(16'h2000);
        we0 = n_we;
        bus.push_req = 1'b1; bus.push_data = 8'h77;
        tick();
        bus.push_req = 1'b0;
        tick();
        chk("rmid_in_wb",    {31'd0, bus.sp_store}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rmid_busy",     {31'd0, bus.busy},    32'd0);
        chk("rmid_release",  {31'd0, dut.bus_drive}, 32'd0);
        chk("rmid_sp_kept",  {16'd0, sp},          32'h1FFF);
        reset = 1'b0;
        tick();
        tick();
        chk("rmid_no_we",    n_we - we0,           32'd0);
        chk("rmid_mem",      {24'd0, mem[16'h1FFF]} === 8'h77 ? 32'd1 : 32'd0, 32'd0);

`ifdef K12A_STACK_LIMIT_EN
        set_sp(16'hFF00);
        we0 = n_we; fault0 = n_fault;
        bus.push_req = 1'b1; bus.push_data = 8'h11;
        tick();
        bus.push_req = 1'b0;
        tick();
        chk("lim_push_fault", {31'd0, bus.fault},  32'd1);
        chk("lim_push_nost",  {31'd0, bus.sp_store}, 32'd0);
        tick();
        chk("lim_push_idle",  {30'd0, bus.busy, bus.fault}, 32'b00);
        chk("lim_push_sp",    {16'd0, sp},         32'hFF00);
        chk("lim_push_nowe",  n_we - we0,          32'd0);
        chk("lim_push_pulse", n_fault - fault0,    32'd1);

        set_sp(16'h0000);
        re0 = n_re; fault0 = n_fault;
        run_op(1'b0, 1'b1, 8'h00, cyc);
        chk("lim_pop_cycles", cyc,                 32'd2);
        chk("lim_pop_pulse",  n_fault - fault0,    32'd1);
        chk("lim_pop_nore",   n_re - re0,          32'd0);
        chk("lim_pop_data",   {24'd0, bus.pop_data}, 32'hA5);
        chk("lim_pop_sp",     {16'd0, sp},         32'h0000);
`else
        // Pop at SP=0xFFFF wraps to 0x0000 with no refusal.
        set_sp(16'hFFFF);
        fault0 = n_fault;
        run_op(1'b0, 1'b1, 8'h00, cyc);
        chk("wrap_cycles",    cyc,                 32'd4);
        chk("wrap_sp",        {16'd0, sp},         32'h0000);
        chk("wrap_pop_data",  {24'd0, bus.pop_data}, 32'hA5);
        chk("wrap_no_fault",  n_fault - fault0,    32'd0);
`endif

        chk("bus_no_clash",   n_clash,             32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/k12a_stack_seq.md
# k12a_stack_seq

Stack sequencer for the K12a CPU: the initiator side of the SP register's `sp_load`/`sp_store` address-bus protocol. On a push or pop request it reads SP off the shared 16-bit address bus, computes the adjusted pointer, writes it back through the bus into SP, and performs the single-byte stack memory access. It sits between the control unit and the SP register / data-memory port.

## Interface

Parameters:
- `STACK_EMPTY`, 16'h0000: SP value meaning stack empty. Used only with the limit feature.
- `STACK_FULL`, 16'hFF00: SP value meaning stack full. Used only with the limit feature.

Ports:
- `cpu_clock`  in  1  sole clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `push_req`  in  1  request a push; sampled only in IDLE
- `pop_req`  in  1  request a pop; sampled only in IDLE
- `push_data`  in  8  byte to push; latched on acceptance
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  one-cycle refusal pulse (limit feature only; else tied 0)
- `pop_data`  out  8  last popped byte; held until the next successful pop
- `sp_load`  out  1  SP register drives `addr_bus`
- `sp_store`  out  1  SP register captures `addr_bus` at the next edge
- `addr_bus`  inout  16  shared address bus; driven by this block only in P_WB, P_MEM, Q_MEM, Q_WB, else 16'hzzzz
- `mem_we`  out  1  data-memory write strobe
- `mem_re`  out  1  data-memory read strobe
- `mem_wdata`  out  8  write data; equals latched push byte
- `mem_rdata`  in  8  read data, combinational from memory within the `mem_re` cycle

## Operation

- Convention: full-descending stack. Push = pre-decrement then write; pop = read then post-increment. Pointer arithmetic is 16-bit modulo 2^16 (0x0000 − 1 = 0xFFFF).
- Internal registers: `state`, `tmp` (16 b), `data` (8 b), `pop_data`.
- States and outputs (all strobes decoded from `state` only):
  - IDLE: nothing driven. `push_req` → P_RD (latch `push_data`); else `pop_req` → Q_RD. Both high: push wins, pop ignored.
  - P_RD: `sp_load`=1; `tmp` ← `addr_bus` − 1. → P_WB.
  - P_WB: drive `tmp`; `sp_store`=1. → P_MEM.
  - P_MEM: drive `tmp`; `mem_we`=1. → DONE.
  - Q_RD: `sp_load`=1; `tmp` ← `addr_bus`. → Q_MEM.
  - Q_MEM: drive `tmp`; `mem_re`=1; `pop_data` ← `mem_rdata` at edge. → Q_WB.
  - Q_WB: drive `tmp` + 1; `sp_store`=1. → DONE.
  - DONE: `done`=1. → IDLE.
- At most one of {`sp_load`, own bus drive} is ever active: no contention.
- Requests arriving while busy are not queued; the requester holds them until `busy` falls.

## Timing

- Reset: state IDLE, `tmp`=0, `data`=0, `pop_data`=8'h00; all outputs 0, `addr_bus` released. Reset mid-sequence aborts at that edge; a partially performed SP writeback or memory write is not undone.
- Push accepted at edge 0 → P_RD cycle 1, P_WB 2, P_MEM 3, DONE 4 (`done`=1). IDLE in cycle 5; next request accepted at edge 5. Pop identical length.
- `pop_data` updates at end of Q_MEM, valid from Q_WB onward.
- `busy` high cycles 1-4 inclusive.

## Configuration

- `K12A_STACK_LIMIT_EN` defined: in P_RD, if `addr_bus` == `STACK_FULL`, push refused; in Q_RD, if `addr_bus` == `STACK_EMPTY`, pop refused. Refusal: next state FAULT (`fault`=1 one cycle, no `sp_store`, no memory access, `pop_data` unchanged) → IDLE. Refused op lasts 2 cycles.
- Not defined: no checks, pointer wraps freely, `fault` constant 0, no FAULT state.

## Test plan

- Reset, SP model=0x0000; push 0xA5 → cycles 1-4 as specified, SP=0xFFFF, mem[0xFFFF]=0xA5, `done` pulse at cycle 4.
- Then pop → `mem_re` at addr 0xFFFF, `pop_data`=0xA5, SP back to 0x0000, `done` one pulse.
- `push_req`=`pop_req`=1 in IDLE with SP=0x1000, push_data=0x3C → push only: SP=0x0FFF, mem[0x0FFF]=0x3C, no `mem_re`.
- Assert `reset` during P_WB → next cycle IDLE, `busy`=0, `addr_bus`=Z, no `mem_we` ever asserted.
- With `K12A_STACK_LIMIT_EN`: SP=0xFF00 push → `fault` pulse cycle 2, SP and memory unchanged; SP=0x0000 pop → `fault`, `pop_data` unchanged.
- Without macro: SP=0xFFFF pop → SP wraps to 0x0000, `fault` stays 0; bus monitor checks no cycle with `sp_load` and own drive both active.
